arb2x1_rr: RTL and testbench

ARB2X1_RR -- requirements
Module: arb2x1_rr

---
 rtl/arb_pkg.sv | 10 +
 rtl/arb_hold_cnt.sv | 22 ++
 rtl/arb2x1_rr.sv | 96 +++++++++
 tb/tb_arb2x1_rr.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared arbiter definitions: state encodings and hold-counter width.
// Each grant has its own state bit, so the grant outputs come straight off the state flops.
package arb_pkg;
   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_OWN1 = 2'b01;
   localparam logic [1:0] ST_OWN2 = 2'b10;

   // Wide enough for MAX_HOLD-1 up to 14.
   localparam int HOLD_W = 4;
endpackage

// File: rtl/arb_hold_cnt.sv
// Ownership hold counter: clears on a new owner, counts while the other side waits,
// and saturates at MAX_HOLD-1.
module arb_hold_cnt
   import arb_pkg::*;
#(
   parameter int MAX_HOLD = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              inc,
   output logic [HOLD_W-1:0] cnt
);
   localparam logic [HOLD_W-1:0] LIMIT = HOLD_W'(MAX_HOLD - 1);

   always_ff @(posedge clk) begin
      if (rst || clr)
         cnt <= '0;
      else if (inc && (cnt != LIMIT))
         cnt <= cnt + 1'b1;
   end
endmodule

// File: rtl/arb2x1_rr.sv
// Two-requester round-robin arbiter with a bounded hold time and a registered mux select.
// It hands ownership directly from one requester to the other, with no idle cycle between.
module arb2x1_rr
   import arb_pkg::*;
#(
   parameter int W        = 1,
   parameter int MAX_HOLD = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req1,
   input  logic         req2,
   input  logic [W-1:0] in1,
   input  logic [W-1:0] in2,
   output logic         gnt1,
   output logic         gnt2,
   output logic         select,
   output logic [W-1:0] out,
   output logic         busy
);
   localparam logic [HOLD_W-1:0] LIMIT = HOLD_W'(MAX_HOLD - 1);

   if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_bad_hold
      $error("arb2x1_rr: MAX_HOLD must be in 1..15");
   end

   logic [1:0]        state, state_nxt;
   logic              last_owner;   // 0 = requester 1, 1 = requester 2
   logic [HOLD_W-1:0] hold_cnt;
   logic              hold_max;
   logic              enter;
   logic              other_req;

   assign hold_max  = (hold_cnt == LIMIT);
   assign enter     = (state_nxt != state) && (state_nxt != ST_IDLE);
   assign other_req = ((state == ST_OWN1) && req2) || ((state == ST_OWN2) && req1);

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: begin
            if (req1 && req2)
               state_nxt = last_owner ? ST_OWN1 : ST_OWN2;
            else if (req1)
               state_nxt = ST_OWN1;
            else if (req2)
               state_nxt = ST_OWN2;
         end
         ST_OWN1: begin
            if (!req1)
               state_nxt = req2 ? ST_OWN2 : ST_IDLE;
            else if (req2 && hold_max)
               state_nxt = ST_OWN2;
         end
         ST_OWN2: begin
            if (!req2)
               state_nxt = req1 ? ST_OWN1 : ST_IDLE;
            else if (req1 && hold_max)
               state_nxt = ST_OWN1;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // last_owner resets to requester 2, so requester 1 wins the first tie.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         last_owner <= 1'b1;
         select     <= 1'b0;
      end else begin
         state <= state_nxt;
         if (enter)
            last_owner <= (state_nxt == ST_OWN2);
         if (state_nxt == ST_OWN1)
            select <= 1'b0;
         else if (state_nxt == ST_OWN2)
            select <= 1'b1;
      end
   end

   arb_hold_cnt #(
      .MAX_HOLD (MAX_HOLD)
   ) u_hold (
      .clk (clk),
      .rst (rst),
      .clr (enter),
      .inc (other_req),
      .cnt (hold_cnt)
   );

   assign gnt1 = state[0];
   assign gnt2 = state[1];
   assign busy = |state;
   assign out  = select ? in2 : in1;
endmodule

// File: tb/tb_arb2x1_rr.sv
// Self-checking bench for arb2x1_rr: vector tables for MAX_HOLD=4 and MAX_HOLD=1 instances,
// with expectations queued at drive time and popped after each clock edge.
module tb_arb2x1_rr;
   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst, req1, req2;
   logic [W-1:0] in1, in2;
   logic         a_gnt1, a_gnt2, a_sel, a_busy;
   logic [W-1:0] a_out;
   logic         b_gnt1, b_gnt2, b_sel, b_busy;
   logic [W-1:0] b_out;

   always #5 clk = ~clk;

   arb2x1_rr #(.W(W), .MAX_HOLD(4)) dut_a (
      .clk(clk), .rst(rst), .req1(req1), .req2(req2), .in1(in1), .in2(in2),
      .gnt1(a_gnt1), .gnt2(a_gnt2), .select(a_sel), .out(a_out), .busy(a_busy));

   arb2x1_rr #(.W(W), .MAX_HOLD(1)) dut_b (
      .clk(clk), .rst(rst), .req1(req1), .req2(req2), .in1(in1), .in2(in2),
      .gnt1(b_gnt1), .gnt2(b_gnt2), .select(b_sel), .out(b_out), .busy(b_busy));

   typedef struct {
      logic         rs, r1, r2;
      logic [W-1:0] i1, i2;
      logic         g1, g2, sl, bz;
      logic [W-1:0] o;
   } vec_t;

   typedef struct {
      logic         g1, g2, sl, bz;
      logic [W-1:0] o;
   } exp_t;

   exp_t sbq[$];
   vec_t tab_a[31];
   vec_t tab_b[12];
   int   n_chk  = 0;
   int   n_pass = 0;

   function automatic vec_t mk(input logic rs, r1, r2, input logic [W-1:0] i1, i2,
                               input logic g1, g2, sl, bz, input logic [W-1:0] o);
      vec_t v;
      v.rs = rs; v.r1 = r1; v.r2 = r2; v.i1 = i1; v.i2 = i2;
      v.g1 = g1; v.g2 = g2; v.sl = sl; v.bz = bz; v.o = o;
      return v;
   endfunction

   task automatic chk(input string nm, input int idx, input logic [W-1:0] act, exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
   endtask

   task automatic run_vec(input vec_t v, input bit use_b, input int idx);
      exp_t e;
      @(negedge clk);
      rst = v.rs; req1 = v.r1; req2 = v.r2; in1 = v.i1; in2 = v.i2;
      e.g1 = v.g1; e.g2 = v.g2; e.sl = v.sl; e.bz = v.bz; e.o = v.o;
      sbq.push_back(e);
      @(posedge clk);
      #1;
      if (sbq.size() == 0) begin
         n_chk++;
         $display("FAIL scoreboard[%0d]: queue empty", idx);
      end else begin
         e = sbq.pop_front();
         if (!use_b) begin
            chk("a_gnt1", idx, W'(a_gnt1), W'(e.g1));
            chk("a_gnt2", idx, W'(a_gnt2), W'(e.g2));
            chk("a_select", idx, W'(a_sel), W'(e.sl));
            chk("a_busy", idx, W'(a_busy), W'(e.bz));
            chk("a_out", idx, a_out, e.o);
         end else begin
            chk("b_gnt1", idx, W'(b_gnt1), W'(e.g1));
            chk("b_gnt2", idx, W'(b_gnt2), W'(e.g2));
            chk("b_select", idx, W'(b_sel), W'(e.sl));
            chk("b_busy", idx, W'(b_busy), W'(e.bz));
            chk("b_out", idx, b_out, e.o);
            chk("b_overlap", idx, W'(b_gnt1 & b_gnt2), W'(0));
         end
      end
   endtask

   initial begin
      rst = 1'b1; req1 = 1'b0; req2 = 1'b0; in1 = 4'hA; in2 = 4'h5;

      // MAX_HOLD=4 table
      tab_a[0] = mk(1, 1, 1, 4'hA, 4'h5, 0, 0, 0, 0, 4'hA);   // reset with requests high
      tab_a[1] = mk(1, 0, 0, 4'hA, 4'h5, 0, 0, 0, 0, 4'hA);
      for (int i = 2; i <= 4; i++)                            // req1 alone
         tab_a[i] = mk(0, 1, 0, 4'hA, 4'h5, 1, 0, 0, 1, 4'hA);
      tab_a[5] = mk(0, 1, 1, 4'hA, 4'h5, 1, 0, 0, 1, 4'hA);
      tab_a[6] = mk(0, 0, 1, 4'hA, 4'h5, 0, 1, 1, 1, 4'h5);   // direct handover
      tab_a[7] = mk(0, 0, 0, 4'h0, 4'h1, 0, 0, 1, 0, 4'h1);   // idle keeps select=1
      tab_a[8] = mk(0, 0, 0, 4'h3, 4'h7, 0, 0, 1, 0, 4'h7);
      tab_a[9] = mk(1, 0, 0, 4'hA, 4'h5, 0, 0, 0, 0, 4'hA);
      for (int i = 10; i <= 13; i++)                          // 4-cycle alternation
         tab_a[i] = mk(0, 1, 1, 4'hA, 4'h5, 1, 0, 0, 1, 4'hA);
      for (int i = 14; i <= 17; i++)
         tab_a[i] = mk(0, 1, 1, 4'hA, 4'h5, 0, 1, 1, 1, 4'h5);
      for (int i = 18; i <= 21; i++)
         tab_a[i] = mk(0, 1, 1, 4'hA, 4'h5, 1, 0, 0, 1, 4'hA);
      tab_a[22] = mk(0, 1, 1, 4'hA, 4'h5, 0, 1, 1, 1, 4'h5);
      tab_a[23] = mk(1, 1, 1, 4'hA, 4'h5, 0, 0, 0, 0, 4'hA);  // reset during OWN2
      tab_a[24] = mk(0, 1, 1, 4'hA, 4'h5, 1, 0, 0, 1, 4'hA);
      tab_a[25] = mk(1, 1, 1, 4'hA, 4'h5, 0, 0, 0, 0, 4'hA);  // reset during OWN1
      tab_a[26] = mk(0, 1, 1, 4'hA, 4'h5, 1, 0, 0, 1, 4'hA);  // tie still to requester 1
      tab_a[27] = mk(0, 0, 0, 4'hA, 4'h5, 0, 0, 0, 0, 4'hA);
      tab_a[28] = mk(0, 1, 1, 4'hA, 4'h5, 0, 1, 1, 1, 4'h5);  // tie after OWN1 goes to 2
      tab_a[29] = mk(0, 0, 1, 4'hA, 4'h5, 0, 1, 1, 1, 4'h5);
      tab_a[30] = mk(0, 1, 0, 4'hA, 4'h5, 1, 0, 0, 1, 4'hA);

      // MAX_HOLD=1 table
      tab_b[0] = mk(1, 0, 0, 4'hA, 4'h5, 0, 0, 0, 0, 4'hA);
      for (int i = 1; i <= 6; i++)
         tab_b[i] = (i % 2 == 1) ? mk(0, 1, 1, 4'hA, 4'h5, 1, 0, 0, 1, 4'hA)
                                 : mk(0, 1, 1, 4'hA, 4'h5, 0, 1, 1, 1, 4'h5);
      tab_b[7] = mk(0, 0, 0, 4'hA, 4'h5, 0, 0, 1, 0, 4'h5);
      for (int i = 8; i <= 10; i++)                           // no waiter: hold ownership
         tab_b[i] = mk(0, 1, 0, 4'hA, 4'h5, 1, 0, 0, 1, 4'hA);
      tab_b[11] = mk(0, 1, 1, 4'hA, 4'h5, 0, 1, 1, 1, 4'h5);

      for (int i = 0; i < 31; i++) run_vec(tab_a[i], 1'b0, i);

      // out follows in1 combinationally between edges while select=0
      @(negedge clk);
      in1 = 4'hC;
      #1;
      chk("a_out_comb", 0, a_out, 4'hC);
      in1 = 4'h3;
      #1;
      chk("a_out_comb", 1, a_out, 4'h3);

      for (int i = 0; i < 12; i++) run_vec(tab_b[i], 1'b1, i);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
